spram_spi_tx: RTL and testbench

Readback transmitter for the SPRAM pattern store: on a start request it reads a run of 16-bit words from the SP256K and serializes them MSB-first onto an SPI mode-0 link, driving its own `sck`, `sdo` and frame-enable `load`. It is the outbound counterpart of the SPI-to-SPRAM write path. The frame format matches what that path accepts: `load` high for the frame, data sampled on the rising `sck`, `sdo` changing while `sck` is low. It sits between the SPRAM read port and the MCU/LED-side SPI pins.

---
 rtl/spram_pkg.sv | 7 +
 rtl/spram_spi_tx_sck_divider.sv | 33 +++
 rtl/spram_spi_tx.sv | 125 ++++++++++++
 tb/tb_spram_spi_tx.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spram_pkg.sv
// spram_pkg: SPRAM constants and readback transmitter state encoding shared by the SPI paths.
package spram_pkg;
    localparam int SPRAM_ADDR_W = 14;
    localparam int SPRAM_DATA_W = 16;
    localparam int SPRAM_WORDS  = 16384;
    typedef enum logic [2:0] {IDLE, FETCH, WAIT, LATCH, SHIFT, FINISH} tx_state_t;
endpackage

// File: rtl/spram_spi_tx_sck_divider.sv
// sck_divider: toggles sck every CLK_DIV enabled clk cycles, low half first, with edge ticks.
module sck_divider #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic en,
    output logic sck,
    output logic rise_tick,
    output logic fall_tick
);
    localparam int CW = $clog2(CLK_DIV + 1);
    logic [CW-1:0] cnt;
    logic          wrap;
    assign wrap      = en && (int'(cnt) == CLK_DIV - 1);
    assign rise_tick = wrap && !sck;
    assign fall_tick = wrap && sck;
    // Half-period counter; disabling parks sck low and restarts the low half.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
            sck <= 1'b0;
        end else if (!en) begin
            cnt <= '0;
            sck <= 1'b0;
        end else if (wrap) begin
            cnt <= '0;
            sck <= ~sck;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end
endmodule

// File: rtl/spram_spi_tx.sv
// spram_spi_tx: reads a run of SPRAM words and streams them MSB-first on an SPI mode-0 link.
// Define SPRAM_SPI_TX_LOOP_EN to keep re-sending the run while start stays high.
module spram_spi_tx
    import spram_pkg::*;
#(
    parameter int ADDR_W  = SPRAM_ADDR_W,
    parameter int CLK_DIV = 4
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    start,
    input  logic [ADDR_W-1:0]       base_addr,
    input  logic [ADDR_W:0]         len,
    output logic [ADDR_W-1:0]       spram_addr,
    output logic                    spram_cs,
    output logic                    spram_we,
    input  logic [SPRAM_DATA_W-1:0] spram_do,
    output logic                    sck,
    output logic                    sdo,
    output logic                    load,
    output logic                    busy,
    output logic                    done
);
    tx_state_t               state;
    logic [ADDR_W-1:0]       addr;
    logic [ADDR_W:0]         remaining;
    logic [SPRAM_DATA_W-2:0] shreg;
    logic [4:0]              bitcnt;
    logic                    rise_tick;
    logic                    fall_tick;

    assign spram_we = 1'b0;

    sck_divider #(.CLK_DIV(CLK_DIV)) u_div (
        .clk       (clk),
        .reset_n   (reset_n),
        .en        (state == SHIFT),
        .sck       (sck),
        .rise_tick (rise_tick),
        .fall_tick (fall_tick)
    );

    // Transfer sequencer; outputs are set on entry to the state they belong to.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            addr       <= '0;
            remaining  <= '0;
            shreg      <= '0;
            bitcnt     <= '0;
            spram_addr <= '0;
            spram_cs   <= 1'b0;
            sdo        <= 1'b0;
            load       <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start && len != '0) begin
                        addr       <= base_addr;
                        remaining  <= len;
                        spram_addr <= base_addr;
                        spram_cs   <= 1'b1;
                        busy       <= 1'b1;
                        state      <= FETCH;
                    end else if (start) begin
                        done  <= 1'b1;
                        busy  <= 1'b1;
                        state <= FINISH;
                    end
                end
                FETCH: begin
                    spram_cs <= 1'b0;
                    state    <= WAIT;
                end
                WAIT: begin
                    shreg     <= spram_do[SPRAM_DATA_W-2:0];
                    sdo       <= spram_do[SPRAM_DATA_W-1];
                    load      <= 1'b1;
                    bitcnt    <= '0;
                    addr      <= addr + 1'b1;
                    remaining <= remaining - 1'b1;
                    state     <= LATCH;
                end
                LATCH: state <= SHIFT;
                SHIFT: begin
                    if (rise_tick)
                        bitcnt <= bitcnt + 5'd1;
                    if (fall_tick && bitcnt == 5'd16) begin
                        if (remaining != '0) begin
                            spram_addr <= addr;
                            spram_cs   <= 1'b1;
                            state      <= FETCH;
                        end
`ifdef SPRAM_SPI_TX_LOOP_EN
                        else if (start && len != '0) begin
                            addr       <= base_addr;
                            remaining  <= len;
                            spram_addr <= base_addr;
                            spram_cs   <= 1'b1;
                            state      <= FETCH;
                        end
`endif
                        else begin
                            load  <= 1'b0;
                            sdo   <= 1'b0;
                            done  <= 1'b1;
                            state <= FINISH;
                        end
                    end else if (fall_tick) begin
                        shreg <= {shreg[SPRAM_DATA_W-3:0], 1'b0};
                        sdo   <= shreg[SPRAM_DATA_W-2];
                    end
                end
                FINISH: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_spram_spi_tx.sv
// tb_spram_spi_tx: directed checks of the SPRAM readback SPI transmitter with a behavioural SPRAM.
module tb_spram_spi_tx;
    localparam int CLK_DIV = 2;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [13:0] base_addr = '0;
    logic [14:0] len = '0;
    logic [13:0] spram_addr;
    logic        spram_cs;
    logic        spram_we;
    logic [15:0] spram_do = '0;
    logic        sck, sdo, load, busy, done;

    logic [15:0] mem [0:16383];

    int n_cmp = 0;
    int n_err = 0;

    int   rises = 0, done_cnt = 0, we_cnt = 0, load_falls = 0, stab_viol = 0;
    int   age = 0, lowrun = 0;
    logic psck = 1'b0, psdo = 1'b0, pload = 1'b0, inframe = 1'b0;
    logic        bits [$];
    logic [13:0] addrs [$];
    int          lows [$];

    int b0, a0, d0, r0, f0, l0, v0;

    spram_spi_tx #(.ADDR_W(14), .CLK_DIV(CLK_DIV)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .base_addr  (base_addr),
        .len        (len),
        .spram_addr (spram_addr),
        .spram_cs   (spram_cs),
        .spram_we   (spram_we),
        .spram_do   (spram_do),
        .sck        (sck),
        .sdo        (sdo),
        .load       (load),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk)
        if (spram_cs) spram_do <= mem[spram_addr];

    always @(negedge clk) begin
        if (spram_we) we_cnt++;
        if (done) done_cnt++;
        if (spram_cs) addrs.push_back(spram_addr);
        if (pload && !load) load_falls++;
        age = (sdo !== psdo) ? 1 : age + 1;
        if (sck && !psck) begin
            bits.push_back(sdo);
            rises++;
            if (age <= CLK_DIV) stab_viol++;
        end
        if (!load) begin
            lowrun  = 0;
            inframe = 1'b0;
        end else if (sck && !psck) begin
            if (inframe) lows.push_back(lowrun);
            inframe = 1'b1;
            lowrun  = 0;
        end else if (!sck) begin
            lowrun++;
        end
        psck  = sck;
        psdo  = sdo;
        pload = load;
    end

    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [95:0] grab(input int from, input int n);
        logic [95:0] v = '0;
        for (int i = 0; i < n; i++) v = {v[94:0], bits[from+i]};
        return v;
    endfunction

    task automatic snap();
        b0 = bits.size(); a0 = addrs.size(); d0 = done_cnt; r0 = rises;
        f0 = load_falls; l0 = lows.size(); v0 = stab_viol;
    endtask

    task automatic go(input logic [13:0] b, input logic [14:0] l);
        base_addr = b;
        len       = l;
        start     = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int k = 0;
        while (done !== 1'b1 && k < 3000) begin
            @(negedge clk);
            k++;
        end
        chk({tag, "_done_seen"}, done, 1'b1);
    endtask

    task automatic wait_rises(input string tag, input int n);
        int k = 0;
        while (rises < n && k < 3000) begin
            @(negedge clk);
            k++;
        end
        chk({tag, "_rises_reached"}, rises >= n, 1'b1);
    endtask

    initial begin
        int bad;
        for (int i = 0; i < 16384; i++) mem[i] = 16'h0000;
        mem[14'h0010] = 16'hA53C;
        mem[14'h0011] = 16'h5AF0;
        mem[14'h3FFE] = 16'h0001;
        mem[14'h3FFF] = 16'h8000;
        mem[14'h0000] = 16'hFFFF;

        repeat (3) @(negedge clk);
        chk("rst_sck", sck, 1'b0);
        chk("rst_sdo", sdo, 1'b0);
        chk("rst_load", load, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_cs", spram_cs, 1'b0);
        chk("rst_we", spram_we, 1'b0);
        chk("rst_addr", spram_addr, 14'h0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_busy", busy, 1'b0);

        snap();
        go(14'h0010, 15'd1);
        chk("c1_cs", spram_cs, 1'b1);
        chk("c1_addr", spram_addr, 14'h0010);
        chk("c1_busy", busy, 1'b1);
        chk("c1_load", load, 1'b0);
        @(posedge clk); #1;
        chk("c2_cs", spram_cs, 1'b0);
        @(posedge clk); #1;
        chk("c3_load", load, 1'b1);
        chk("c3_sdo", sdo, 1'b1);
        wait_done("single");
        chk("single_done_load", load, 1'b0);
        chk("single_done_busy", busy, 1'b1);
        @(negedge clk);
        chk("single_done_pulse", done, 1'b0);
        chk("single_busy_fall", busy, 1'b0);
        chk("single_bits", grab(b0, 16), 16'hA53C);
        chk("single_rises", rises - r0, 16);
        chk("single_done_cnt", done_cnt - d0, 1);
        chk("single_reads", addrs.size() - a0, 1);
        chk("single_raddr", addrs[a0], 14'h0010);

        repeat (3) @(negedge clk);
        snap();
        go(14'h3FFE, 15'd3);
        wait_done("multi");
        @(negedge clk);
        chk("multi_bits", grab(b0, 48), 48'h0001_8000_FFFF);
        chk("multi_rises", rises - r0, 48);
        chk("multi_reads", addrs.size() - a0, 3);
        chk("multi_raddr", {addrs[a0], addrs[a0+1], addrs[a0+2]}, {14'h3FFE, 14'h3FFF, 14'h0000});
        chk("multi_load_falls", load_falls - f0, 1);
        chk("multi_low_runs", lows.size() - l0, 47);
        bad = 0;
        for (int k = 0; k < 47; k++)
            if (lows[l0+k] != ((k % 16 == 15) ? CLK_DIV + 3 : CLK_DIV)) bad++;
        chk("multi_gap_shape", bad, 0);
        chk("multi_done_cnt", done_cnt - d0, 1);

        repeat (3) @(negedge clk);
        snap();
        go(14'h0020, 15'd0);
        chk("len0_done_c1", done, 1'b1);
        chk("len0_load", load, 1'b0);
        @(posedge clk); #1;
        chk("len0_done_off", done, 1'b0);
        chk("len0_busy_off", busy, 1'b0);
        repeat (3) @(negedge clk);
        chk("len0_rises", rises - r0, 0);
        chk("len0_done_cnt", done_cnt - d0, 1);
        chk("len0_reads", addrs.size() - a0, 0);

        snap();
        go(14'h0010, 15'd2);
        wait_rises("repulse_a", r0 + 5);
        base_addr = 14'h3FFE;
        len       = 15'd3;
        start     = 1'b1;
        repeat (3) @(negedge clk);
        start = 1'b0;
        wait_rises("repulse_b", r0 + 20);
        len   = 15'd0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("repulse");
        repeat (4) @(negedge clk);
        chk("repulse_bits", grab(b0, 32), 32'hA53C_5AF0);
        chk("repulse_rises", rises - r0, 32);
        chk("repulse_done_cnt", done_cnt - d0, 1);
        chk("repulse_raddr", {addrs[a0], addrs[a0+1]}, {14'h0010, 14'h0011});
        chk("repulse_idle", busy, 1'b0);

`ifdef SPRAM_SPI_TX_LOOP_EN
        snap();
        base_addr = 14'h0010;
        len       = 15'd2;
        start     = 1'b1;
        wait_rises("loop_half", r0 + 80);
        chk("loop_no_early_done", done_cnt - d0, 0);
        start = 1'b0;
        wait_done("loop");
        @(negedge clk);
        chk("loop_bits", grab(b0, 96), {3{32'hA53C_5AF0}});
        chk("loop_rises", rises - r0, 96);
        chk("loop_reads", addrs.size() - a0, 6);
        chk("loop_done_cnt", done_cnt - d0, 1);
        chk("loop_load_falls", load_falls - f0, 1);
`else
        snap();
        base_addr = 14'h0010;
        len       = 15'd1;
        start     = 1'b1;
        wait_rises("held", r0 + 8);
        start = 1'b0;
        wait_done("held");
        @(negedge clk);
        chk("held_bits", grab(b0, 16), 16'hA53C);
        chk("held_rises", rises - r0, 16);
        chk("held_done_cnt", done_cnt - d0, 1);
`endif

        repeat (3) @(negedge clk);
        snap();
        go(14'h3FFE, 15'd3);
        wait_rises("rst_mid", r0 + 23);
        chk("rst_mid_pre_load", load, 1'b1);
        chk("rst_mid_pre_sck", sck, 1'b1);
        #2 reset_n = 1'b0;
        #1;
        chk("rst_mid_async", {sck, sdo, load, busy, done, spram_cs, spram_we, spram_addr}, 21'h0);
        repeat (2) @(negedge clk);
        chk("rst_mid_hold", {sck, sdo, load, busy, done, spram_cs, spram_we, spram_addr}, 21'h0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_mid_no_done", done_cnt - d0, 0);
        snap();
        go(14'h0010, 15'd1);
        wait_done("rst_fresh");
        @(negedge clk);
        chk("rst_fresh_bits", grab(b0, 16), 16'hA53C);
        chk("rst_fresh_rises", rises - r0, 16);
        chk("rst_fresh_done_cnt", done_cnt - d0, 1);
        chk("rst_fresh_raddr", addrs[a0], 14'h0010);

        chk("we_never", we_cnt, 0);
        chk("sdo_setup", stab_viol, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
